// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage and later requantisation stages.
package mac_pkg;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned Q15_W  = 16;

  localparam int Q15_MAX = 32767;
  localparam int Q15_MIN = -32768;

  typedef enum logic [1:0] {
    PREC_Q1_6  = 2'd0,
    PREC_Q1_14 = 2'd1,
    PREC_Q1_30 = 2'd2,
    PREC_RSVD  = 2'd3
  } prec_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/mac_accum_if.sv
// Product-beat input stream and vector-result output stream of the MAC accumulate stage.
interface mac_accum_if #(
  parameter int unsigned CNT_W = 10
) ();
  import mac_pkg::*;

  logic [PROD_W-1:0] prod_in;
  prec_e             prec_mode;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready;

  logic [Q15_W-1:0]  sum_out;
  logic [CNT_W-1:0]  sum_count;
  logic              sum_ovf;
  logic              sum_valid;
  logic              sum_ready;

  modport master (
    output prod_in, prec_mode, prod_valid, prod_last, sum_ready,
    input  prod_ready, sum_out, sum_count, sum_ovf, sum_valid
  );

  modport slave (
    input  prod_in, prec_mode, prod_valid, prod_last, sum_ready,
    output prod_ready, sum_out, sum_count, sum_ovf, sum_valid
  );

endinterface

// File: rtl/sat_round_q15.sv
// Round-half-up a signed Q*.30 value to Q0.15 and saturate to the 16-bit range.
module sat_round_q15
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [Q15_W-1:0] q_o,
  output logic                    sat_o
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HALF = EXT_W'(16384);
  localparam logic signed [EXT_W-1:0] HI   = EXT_W'(Q15_MAX);
  localparam logic signed [EXT_W-1:0] LO   = EXT_W'(Q15_MIN);

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  // One extra bit keeps the rounding bias from wrapping a saturated accumulator.
  always_comb begin
    biased  = EXT_W'(acc_i) + HALF;
    shifted = biased >>> 15;
    sat_o   = 1'b0;
    q_o     = shifted[Q15_W-1:0];
    if (shifted > HI) begin
      q_o   = Q15_W'(Q15_MAX);
      sat_o = 1'b1;
    end else if (shifted < LO) begin
      q_o   = Q15_W'(Q15_MIN);
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Per-vector accumulation of aligned signed products, then round/saturate to Q0.15 into a
// one-entry result register with backpressure.
module mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  mac_accum_if.slave  bus
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  state_q;
  prec_e                   mode_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic [Q15_W-1:0]        sum_out_q;
  logic [CNT_W-1:0]        sum_count_q;
  logic                    sum_ovf_q;
  logic                    sum_valid_q;

  prec_e                   eff_mode;
  logic signed [ACC_W-1:0] aligned;
  logic signed [EXT_W-1:0] sum_w;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    accept;
  logic [Q15_W-1:0]        res_q15;
  logic                    res_sat;

  assign bus.prod_ready = !(sum_valid_q && !bus.sum_ready);
  assign accept         = bus.prod_valid && bus.prod_ready;

  // Mode is taken live on a vector's first beat, from the latched copy afterwards.
  assign eff_mode = (state_q == S_IDLE) ? bus.prec_mode : mode_q;

  always_comb begin
    case (eff_mode)
      PREC_Q1_6:  aligned = ACC_W'($signed(bus.prod_in[7:0])) <<< 24;
      PREC_Q1_14: aligned = ACC_W'($signed(bus.prod_in[15:0])) <<< 16;
      default:    aligned = ACC_W'($signed(bus.prod_in));
    endcase
  end

  // Saturating add: overflow shows as disagreement between the guard bit and the MSB.
  always_comb begin
    sum_w   = EXT_W'(acc_q) + EXT_W'(aligned);
    add_ovf = (sum_w[ACC_W] != sum_w[ACC_W-1]);
    acc_sat = sum_w[ACC_W-1:0];
    if (add_ovf) begin
      acc_sat = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    acc_d = acc_sat;
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_d = ovf_q | add_ovf;
    if (state_q == S_IDLE) begin
      acc_d = aligned;
      cnt_d = CNT_W'(1);
      ovf_d = (bus.prec_mode == PREC_RSVD);
    end
  end

  sat_round_q15 #(.ACC_W(ACC_W)) u_sat_round (
    .acc_i (acc_d),
    .q_o   (res_q15),
    .sat_o (res_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= PREC_Q1_30;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_out_q   <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      if (sum_valid_q && bus.sum_ready) begin
        sum_valid_q <= 1'b0;
      end
      if (accept) begin
        if (bus.prod_last) begin
          // A new result overrides the drop from a same-cycle handshake.
          state_q     <= S_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          sum_out_q   <= res_q15;
          sum_count_q <= cnt_d;
          sum_ovf_q   <= ovf_d | res_sat;
          sum_valid_q <= 1'b1;
        end else begin
          state_q <= S_ACC;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          if (state_q == S_IDLE) begin
            mode_q <= eff_mode;
          end
        end
      end
    end
  end

  assign bus.sum_out   = sum_out_q;
  assign bus.sum_count = sum_count_q;
  assign bus.sum_ovf   = sum_ovf_q;
  assign bus.sum_valid = sum_valid_q;

endmodule

// File: tb/tb_mac_accum.sv
// Randomised and directed bench for mac_accum against a per-vector arithmetic model.
module tb_mac_accum;
  import mac_pkg::*;

  localparam int unsigned ACC_W = 40;
  localparam int unsigned CNT_W = 10;
  localparam longint ACC_MAX = 64'sd549755813887;
  localparam longint ACC_MIN = -64'sd549755813888;
  localparam int     CNT_SAT = 1023;

  logic clk = 1'b0;
  logic rst;

  mac_accum_if #(.CNT_W(CNT_W)) bus ();

  mac_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected state of the result register
  bit          m_valid;
  logic [15:0] m_out;
  int          m_cnt;
  bit          m_ovf;
  // Vector in progress
  bit          v_open;
  int          v_mode;
  longint      v_acc;
  int          v_cnt;
  bit          v_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint align(input int m, input logic [31:0] p);
    case (m)
      0:       return longint'($signed(p[7:0])) * 64'sd16777216;
      1:       return longint'($signed(p[15:0])) * 64'sd65536;
      default: return longint'($signed(p));
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    v_open  = 1'b0;
  endtask

  task automatic model_beat(input int pm, input logic [31:0] pd, input bit pl);
    int     m;
    longint r;
    m = v_open ? v_mode : pm;
    if (!v_open) begin
      v_mode = pm;
      v_acc  = align(m, pd);
      v_cnt  = 1;
      v_ovf  = (pm == 3);
      v_open = 1'b1;
    end else begin
      v_acc = v_acc + align(m, pd);
      if (v_acc > ACC_MAX) begin v_acc = ACC_MAX; v_ovf = 1'b1; end
      else if (v_acc < ACC_MIN) begin v_acc = ACC_MIN; v_ovf = 1'b1; end
      if (v_cnt < CNT_SAT) v_cnt++;
    end
    if (pl) begin
      r = (v_acc + 64'sd16384) >>> 15;
      if (r > 32767) begin r = 32767; v_ovf = 1'b1; end
      else if (r < -32768) begin r = -32768; v_ovf = 1'b1; end
      m_valid = 1'b1;
      m_out   = 16'(r);
      m_cnt   = v_cnt;
      m_ovf   = v_ovf;
      v_open  = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, update the model, check outputs at the next falling edge.
  task automatic step(input bit pv, input bit pl, input int pm, input logic [31:0] pd, input bit sr);
    bit exp_rdy;
    logic [1:0] pm2;
    pm2            = pm[1:0];
    bus.prod_valid = pv;
    bus.prod_last  = pl;
    bus.prec_mode  = prec_e'(pm2);
    bus.prod_in    = pd;
    bus.sum_ready  = sr;
    #1;
    exp_rdy = !(m_valid && !sr);
    chk("prod_ready", 64'(bus.prod_ready), 64'(exp_rdy));
    if (m_valid && sr) m_valid = 1'b0;
    if (pv && exp_rdy) model_beat(pm, pd, pl);
    @(posedge clk);
    @(negedge clk);
    chk("sum_valid", 64'(bus.sum_valid), 64'(m_valid));
    if (m_valid) begin
      chk("sum_out",   64'(bus.sum_out),   64'(m_out));
      chk("sum_count", 64'(bus.sum_count), 64'(m_cnt));
      chk("sum_ovf",   64'(bus.sum_ovf),   64'(m_ovf));
    end
  endtask

  task automatic vec(input int pm, input logic [31:0] pd, input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == n - 1, pm, pd, 1'b1);
  endtask

  // Hand-computed expectation for the result currently presented
  task automatic lit(input string name, input logic [15:0] out, input int cnt, input bit ovf);
    chk({name, " valid"}, 64'(bus.sum_valid), 64'd1);
    chk({name, " out"},   64'(bus.sum_out),   64'(out));
    chk({name, " count"}, 64'(bus.sum_count), 64'(cnt));
    chk({name, " ovf"},   64'(bus.sum_ovf),   64'(ovf));
  endtask

  initial begin
    rst            = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    bus.prec_mode  = PREC_Q1_30;
    bus.prod_in    = '0;
    bus.sum_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("reset sum_out",   64'(bus.sum_out),   64'd0);
    chk("reset sum_count", 64'(bus.sum_count), 64'd0);
    chk("reset sum_ovf",   64'(bus.sum_ovf),   64'd0);
    rst = 1'b0;
    #1;
    chk("reset prod_ready", 64'(bus.prod_ready), 64'd1);
    @(negedge clk);

    vec(2, 32'h1000_0000, 2);  lit("t1 quarter", 16'h4000, 2, 1'b0);
    vec(2, 32'h2000_0000, 4);  lit("t2 pos sat", 16'h7FFF, 4, 1'b1);
    vec(2, 32'hE000_0000, 4);  lit("t2 neg sat", 16'h8000, 4, 1'b1);

    step(1'b1, 1'b0, 0, 32'h0000_0010, 1'b1);
    step(1'b1, 1'b1, 1, 32'h0000_1000, 1'b1);
    lit("t3 mode lock", 16'h2000, 2, 1'b0);

    vec(2, 32'h0000_4000, 1);  lit("t4 half", 16'h0001, 1, 1'b0);
    vec(2, 32'h0000_3FFF, 1);  lit("t4 below", 16'h0000, 1, 1'b0);
    vec(2, 32'hFFFF_C000, 1);  lit("t4 neg half", 16'h0000, 1, 1'b0);
    vec(3, 32'h1000_0000, 2);  lit("rsvd mode", 16'h4000, 2, 1'b1);

    vec(2, 32'h1000_0000, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2, 32'h7FFF_FFFF, 1'b0);
    lit("t5 held", 16'h2000, 1, 1'b0);
    step(1'b1, 1'b1, 2, 32'h0800_0000, 1'b1);
    lit("t5 replace", 16'h1000, 1, 1'b0);
    step(1'b0, 1'b0, 0, 32'h0, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2, 32'h1234_5678, 1'b1);
    rst            = 1'b1;
    bus.prod_valid = 1'b0;
    #1;
    chk("t6 rst sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("t6 rst sum_out",   64'(bus.sum_out),   64'd0);
    chk("t6 rst sum_count", 64'(bus.sum_count), 64'd0);
    chk("t6 rst sum_ovf",   64'(bus.sum_ovf),   64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    vec(2, 32'h0800_0000, 1);  lit("t6 after rst", 16'h1000, 1, 1'b0);

    vec(2, 32'h8000_0000, 260);  lit("acc min sat", 16'h8000, 260, 1'b1);
    vec(2, 32'h7FFF_FFFF, 260);  lit("acc max sat", 16'h7FFF, 260, 1'b1);
    vec(0, 32'h0000_0000, 1030); lit("count sat", 16'h0000, CNT_SAT, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pd;
      pd = $urandom;
      if ($urandom_range(0, 3) == 0) pd = {pd[31], 31'h7FFF_F000};
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)), pd, $urandom_range(0, 9) < 6);
    end
    step(1'b0, 1'b0, 0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
